// File: rtl/core_mem_port.sv
// Per-core data-memory initiator: issues one load/store to the shared controller,
// stalls the core through the memAV handshake and returns read data or a timeout error.
module core_mem_port #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             rstN,
  input  logic             coreS,
  input  logic             ld_req,
  input  logic             st_req,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic             stall,
  output logic [WIDTH-1:0] rdata_out,
  output logic             rdata_valid,
  output logic             err,
  output logic             memREAD,
  output logic             memWE,
  output logic [WIDTH-1:0] AR,
  output logic [WIDTH-1:0] DR,
  input  logic             memAV,
  input  logic [WIDTH-1:0] MEM
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_nxt, we_nxt, valid_nxt, err_nxt;
  logic [WIDTH-1:0] ar_nxt, dr_nxt, rdata_nxt;
  logic             timeout_hit;

  assign stall       = (state != S_IDLE);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

  // Next-state and next-output decode; completion is checked before timeout so it wins a tie.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = memREAD;
    we_nxt    = memWE;
    ar_nxt    = AR;
    dr_nxt    = DR;
    rdata_nxt = rdata_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    if (coreS) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      rd_nxt    = 1'b0;
      we_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (st_req) begin
            ar_nxt    = addr_in;
            dr_nxt    = wdata_in;
            we_nxt    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_ISSUE;
          end else if (ld_req) begin
            ar_nxt    = addr_in;
            rd_nxt    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (timeout_hit) begin
            rd_nxt    = 1'b0;
            we_nxt    = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (memAV) state_nxt = S_ACK;
          end
        end
        S_ACK: begin
          if (!memAV) begin
            if (memREAD) begin
              rdata_nxt = MEM;
              valid_nxt = 1'b1;
            end
            rd_nxt    = 1'b0;
            we_nxt    = 1'b0;
            state_nxt = S_DONE;
          end else if (timeout_hit) begin
            rd_nxt    = 1'b0;
            we_nxt    = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // One dead cycle with requests low between transactions.
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          rd_nxt    = 1'b0;
          we_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge rstN) begin
    if (!rstN) begin
      state       <= S_IDLE;
      cnt         <= '0;
      memREAD     <= 1'b0;
      memWE       <= 1'b0;
      AR          <= '0;
      DR          <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      memREAD     <= rd_nxt;
      memWE       <= we_nxt;
      AR          <= ar_nxt;
      DR          <= dr_nxt;
      rdata_out   <= rdata_nxt;
      rdata_valid <= valid_nxt;
      err         <= err_nxt;
    end
  end

endmodule
